// File: rtl/pipe_stage_reg.sv
// Two-entry elastic pipeline stage: a main register driving the outputs plus a skid
// register, with a flush that discards held beats and a saturating discard counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W        = 160,
    parameter int unsigned CTRL_W        = 16,
    parameter bit          ZERO_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [15:0]       flush_cnt
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic                in_ready_q, out_valid_q;
    logic                accept_c, take_c;
    logic [CNT_W:0]      flush_sum_c;

    assign accept_c    = in_valid && in_ready_q;
    assign take_c      = out_valid_q && out_ready && !stall;
    assign flush_sum_c = {1'b0, flush_cnt_q} + (CNT_W+1)'(state_q) + (CNT_W+1)'(accept_c);

    // Next-state and register-load logic; flush overrides normal flow.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (ZERO_ON_FLUSH) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
            flush_cnt_d = flush_sum_c[CNT_W] ? {CNT_W{1'b1}} : flush_sum_c[CNT_W-1:0];
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    if (accept_c && take_c) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (accept_c) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = SKID;
                    end else if (take_c) begin
                        // Control reads zero whenever nothing is presented.
                        main_ctrl_d = '0;
                        state_d     = EMPTY;
                    end
                end
                SKID: begin
                    if (take_c) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_ctrl_d = '0;
                        state_d     = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and payload registers; ready/valid come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            flush_cnt_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            flush_cnt_q <= flush_cnt_d;
            in_ready_q  <= (state_d != SKID);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = 2'(state_q);
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a reference occupancy/counter model plus a
// scoreboard queue of accepted beats checked against the outputs every cycle.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 160;
    localparam int unsigned CTRL_W = 16;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst, flush, stall, in_valid, out_ready;
    logic              in_ready, out_valid;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [1:0]        occupancy;
    logic [15:0]       flush_cnt;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    beat_t       sb[$];
    beat_t       cur;
    logic [15:0] next_ctrl;
    int          m_occ;
    logic [15:0] m_cnt;
    bit          m_zero;
    bit          armed;
    int          n_cmp;
    int          n_fail;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [15:0] c);
        beat_t b;
        b.ctrl = c;
        b.data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return b;
    endfunction

    // Check outputs against the model, then advance the model and one clock.
    task automatic cycle();
        bit acc, tk;
        int s;
        if (armed) begin
            check("occupancy", 192'(occupancy), 192'(m_occ));
            check("in_ready", 192'(in_ready), 192'(m_occ != 2));
            check("out_valid", 192'(out_valid), 192'(m_occ != 0));
            check("flush_cnt", 192'(flush_cnt), 192'(m_cnt));
            if (m_occ != 0) begin
                check("out_ctrl", 192'(out_ctrl), 192'(sb[0].ctrl));
                check("out_data", 192'(out_data), 192'(sb[0].data));
            end else begin
                check("out_ctrl_idle", 192'(out_ctrl), 192'(0));
                if (m_zero) check("out_data_zero", 192'(out_data), 192'(0));
            end
        end
        in_data = cur.data;
        in_ctrl = cur.ctrl;
        acc = in_valid && (m_occ != 2);
        tk  = (m_occ != 0) && out_ready && !stall;
        if (rst) begin
            sb.delete();
            m_occ  = 0;
            m_cnt  = 16'h0;
            m_zero = 1'b1;
            armed  = 1'b1;
        end else if (flush) begin
            s      = int'(m_cnt) + m_occ + int'(acc);
            m_cnt  = (s > 65535) ? 16'hFFFF : 16'(s);
            sb.delete();
            m_occ  = 0;
            m_zero = 1'b1;
        end else begin
            if (tk) void'(sb.pop_front());
            if (acc) begin
                sb.push_back(cur);
                m_zero = 1'b0;
            end
            m_occ = m_occ + int'(acc) - int'(tk);
        end
        if (acc) begin
            cur       = mk(next_ctrl);
            next_ctrl = next_ctrl + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic [15:0] c);
        cur       = mk(c);
        next_ctrl = c + 16'd1;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; armed = 1'b0;
        m_occ = 0; m_cnt = 16'h0; m_zero = 1'b1;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_ctrl(16'h0001);
        in_data = cur.data; in_ctrl = cur.ctrl;
        #1;
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        // Streaming: 8 beats, one per cycle, occupancy stays at 1
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (8) cycle();
        in_valid = 1'b0;
        cycle(); cycle();

        // Flush in FULL without a new beat discards one
        set_ctrl(16'h0010);
        in_valid = 1'b1; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        check("flush_full_cnt", 192'(flush_cnt), 192'(16'd1));

        // Backpressure: three offered, two held, drain in order
        set_ctrl(16'h0020);
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (3) cycle();
        check("bp_occ", 192'(occupancy), 192'(2'd2));
        check("bp_in_ready", 192'(in_ready), 192'(1'b0));
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cycle();

        // Flush in SKID with a beat offered
        set_ctrl(16'h0030);
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (2) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_skid_cnt", 192'(flush_cnt), 192'(16'd3));
        check("flush_skid_ctrl", 192'(out_ctrl), 192'(0));
        cycle();

        // Stall holds 0x00AA for four cycles, released on the fifth
        set_ctrl(16'h00AA);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0; out_ready = 1'b1; stall = 1'b1;
        repeat (4) cycle();
        check("stall_hold", 192'(out_ctrl), 192'(16'h00AA));
        stall = 1'b0;
        cycle(); cycle();

        // Stall with accepts fills to SKID, then flush+stall acts as flush
        set_ctrl(16'h0040);
        stall = 1'b1; in_valid = 1'b1;
        repeat (3) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        cycle();

        // Drive flush_cnt up to 0xFFFE one discarded beat per cycle
        flush = 1'b1; in_valid = 1'b1;
        while (m_cnt < 16'hFFFE) cycle();
        flush = 1'b0; out_ready = 1'b0;
        set_ctrl(16'h0050);
        repeat (3) cycle();
        flush = 1'b1;
        cycle();
        check("sat_cnt", 192'(flush_cnt), 192'(16'hFFFF));
        cycle();
        flush = 1'b0;
        cycle();

        // Reset while in SKID drops everything and clears the counter
        set_ctrl(16'h0060);
        repeat (2) cycle();
        in_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_in_ready", 192'(in_ready), 192'(1'b1));
        check("rst_cnt", 192'(flush_cnt), 192'(16'h0));
        cycle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
